// File: rtl/debug_display_scan.sv
// Debug display selector: shows one of NCH source channels, chosen manually,
// by a timed round-robin scan, or frozen with on-demand snapshots.
module debug_display_scan #(
    parameter int NCH   = 8,
    parameter int W     = 32,
    parameter int DWELL = 16,
    localparam int SW   = ($clog2(NCH) > 1) ? $clog2(NCH) : 1,
    localparam int CW   = ($clog2(DWELL) > 1) ? $clog2(DWELL) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH*W-1:0]  ch_data,
    input  logic [SW-1:0]     sel,
    input  logic [1:0]        mode,
    input  logic              snap,
    output logic [W-1:0]      outputs,
    output logic [SW-1:0]     out_ch,
    output logic              chg,
    output logic              frozen
);

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        SCAN   = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t          state;
    state_t          mode_state;
    logic [SW-1:0]   scan_idx;
    logic [SW-1:0]   scan_idx_nxt;
    logic [CW-1:0]   dwell_cnt;
    logic [CW-1:0]   dwell_cnt_nxt;
    logic [W-1:0]    chan [NCH];
    logic [W-1:0]    man_val;
    logic [W-1:0]    scan_val;
    logic [W-1:0]    out_nxt;
    logic [SW-1:0]   ch_nxt;

    always_comb begin
        for (int unsigned k = 0; k < NCH; k++) begin
            chan[k] = ch_data[k*W +: W];
        end
    end

    always_comb begin
        unique case (mode)
            2'b01:   mode_state = SCAN;
            2'b10:   mode_state = HOLD;
            default: mode_state = MANUAL;
        endcase
    end

    // Out-of-range selects fall through to the constant 1 marker value.
    always_comb begin
        man_val = W'(1);
        for (int unsigned k = 0; k < NCH; k++) begin
            if (sel == SW'(k)) man_val = chan[k];
        end
    end

    // The mode sampled at an edge governs that edge; state only remembers the
    // previous mode so SCAN entry can restart the index and dwell counter.
    always_comb begin
        scan_idx_nxt  = scan_idx;
        dwell_cnt_nxt = dwell_cnt;
        if (mode_state == SCAN) begin
            if (state != SCAN) begin
                scan_idx_nxt  = '0;
                dwell_cnt_nxt = '0;
            end else if (dwell_cnt == CW'(DWELL - 1)) begin
                dwell_cnt_nxt = '0;
                scan_idx_nxt  = (scan_idx == SW'(NCH - 1)) ? '0 : scan_idx + 1'b1;
            end else begin
                dwell_cnt_nxt = dwell_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        scan_val = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (scan_idx_nxt == SW'(k)) scan_val = chan[k];
        end
    end

    always_comb begin
        out_nxt = outputs;
        ch_nxt  = out_ch;
        unique case (mode_state)
            SCAN: begin
                out_nxt = scan_val;
                ch_nxt  = scan_idx_nxt;
            end
            HOLD: begin
                if (snap) begin
                    out_nxt = man_val;
                    ch_nxt  = sel;
                end
            end
            default: begin
                out_nxt = man_val;
                ch_nxt  = sel;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= MANUAL;
            scan_idx  <= '0;
            dwell_cnt <= '0;
            outputs   <= '0;
            out_ch    <= '0;
            chg       <= 1'b0;
            frozen    <= 1'b0;
        end else begin
            state     <= mode_state;
            scan_idx  <= scan_idx_nxt;
            dwell_cnt <= dwell_cnt_nxt;
            outputs   <= out_nxt;
            out_ch    <= ch_nxt;
            chg       <= (ch_nxt != out_ch);
            frozen    <= (mode_state == HOLD);
        end
    end

endmodule

// File: tb/tb_debug_display_scan.sv
// Directed bench for debug_display_scan: expected display state is queued as
// each cycle is driven and compared after the edge that produces it.
module tb_debug_display_scan;

    localparam int NCH   = 6;
    localparam int W     = 32;
    localparam int DWELL = 3;
    localparam int SW    = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH*W-1:0]  ch_data;
    logic [SW-1:0]     sel;
    logic [1:0]        mode;
    logic              snap;
    logic [W-1:0]      outputs;
    logic [SW-1:0]     out_ch;
    logic              chg;
    logic              frozen;

    typedef struct {
        logic [31:0] o;
        logic [2:0]  c;
        logic        g;
        logic        f;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [2:0]  last_ch;

    debug_display_scan #(.NCH(NCH), .W(W), .DWELL(DWELL)) dut (
        .clk(clk), .rst_n(rst_n), .ch_data(ch_data), .sel(sel), .mode(mode),
        .snap(snap), .outputs(outputs), .out_ch(out_ch), .chg(chg), .frozen(frozen)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic set_ch(input int k, input logic [31:0] v);
        ch_data[k*W +: W] = v;
    endtask

    task automatic restore_all();
        for (int k = 0; k < NCH; k++) set_ch(k, 32'hA000_0000 + 32'(k));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".outputs"}, outputs, 32'h0);
        check({tag, ".out_ch"}, 32'(out_ch), 32'h0);
        check({tag, ".chg"}, 32'(chg), 32'h0);
        check({tag, ".frozen"}, 32'(frozen), 32'h0);
    endtask

    // Drive one cycle, queue its expected result, and check it after the edge.
    task automatic cyc(input string tag, input logic [1:0] m, input logic [2:0] s,
                       input logic sn, input logic [31:0] eo, input logic [2:0] ec,
                       input logic ef);
        exp_t e;
        mode = m;
        sel  = s;
        snap = sn;
        sb.push_back('{o: eo, c: ec, g: (ec != last_ch), f: ef});
        last_ch = ec;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, ".outputs"}, outputs, e.o);
        check({tag, ".out_ch"}, 32'(out_ch), 32'(e.c));
        check({tag, ".chg"}, 32'(chg), 32'(e.g));
        check({tag, ".frozen"}, 32'(frozen), 32'(e.f));
    endtask

    initial begin
        logic [2:0] idx;
        logic [31:0] d;

        rst_n = 1'b0;
        mode  = 2'b00;
        sel   = 3'd0;
        snap  = 1'b0;
        restore_all();
        last_ch = 3'd0;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < NCH; k++) set_ch(k, $urandom);
            sel  = 3'(i + 1);
            mode = 2'(i);
            check_reset_state("reset");
        end
        restore_all();
        mode = 2'b00;
        rst_n = 1'b1;

        cyc("man4", 2'b00, 3'd4, 1'b0, 32'hA000_0004, 3'd4, 1'b0);
        cyc("man4_stay", 2'b00, 3'd4, 1'b0, 32'hA000_0004, 3'd4, 1'b0);
        cyc("oor7", 2'b00, 3'd7, 1'b0, 32'h0000_0001, 3'd7, 1'b0);
        cyc("oor7_stay", 2'b00, 3'd7, 1'b0, 32'h0000_0001, 3'd7, 1'b0);
        cyc("mode11", 2'b11, 3'd1, 1'b0, 32'hA000_0001, 3'd1, 1'b0);
        cyc("man0", 2'b00, 3'd0, 1'b0, 32'hA000_0000, 3'd0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            idx = 3'((i / DWELL) % NCH);
            d = 32'hA000_0000 + 32'(idx);
            if (i == 1) begin
                set_ch(0, 32'h1234_5678);
                d = 32'h1234_5678;
            end
            if (i == 2) set_ch(0, 32'hA000_0000);
            cyc("scan", 2'b01, 3'd4, 1'b1, d, idx, 1'b0);
        end

        for (int k = 0; k < NCH; k++) set_ch(k, 32'h5A5A_0000 + 32'(k));
        cyc("hold_entry", 2'b10, 3'd3, 1'b0, 32'hA000_0000, 3'd0, 1'b1);
        cyc("hold", 2'b10, 3'd3, 1'b0, 32'hA000_0000, 3'd0, 1'b1);
        restore_all();
        cyc("snap2", 2'b10, 3'd2, 1'b1, 32'hA000_0002, 3'd2, 1'b1);
        set_ch(2, 32'hDEAD_BEEF);
        cyc("held_after_snap", 2'b10, 3'd4, 1'b0, 32'hA000_0002, 3'd2, 1'b1);
        cyc("held_after_snap2", 2'b10, 3'd4, 1'b0, 32'hA000_0002, 3'd2, 1'b1);
        restore_all();
        cyc("unhold_man5", 2'b00, 3'd5, 1'b1, 32'hA000_0005, 3'd5, 1'b0);

        for (int i = 0; i < 10; i++) begin
            idx = 3'(i / DWELL);
            cyc("scan2", 2'b01, 3'd4, 1'b1, 32'hA000_0000 + 32'(idx), idx, 1'b0);
        end
        check("at_ch3", 32'(out_ch), 32'd3);

        rst_n = 1'b0;
        #1;
        check_reset_state("async_rst");
        @(posedge clk);
        #1;
        check_reset_state("rst_held");
        mode = 2'b01;
        rst_n = 1'b1;
        last_ch = 3'd0;
        for (int i = 0; i < 4; i++) begin
            idx = 3'(i / DWELL);
            cyc("rst_scan", 2'b01, 3'd5, 1'b0, 32'hA000_0000 + 32'(idx), idx, 1'b0);
        end

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
